po2_term_mac_seq: RTL and testbench

- Sequential, parametrised successor to the single-cycle two-term shift-add multiplier.
- Multiplies operand a by a weight encoded as up to MAX_TERMS signed power-of-two terms: weight = Σ sign_k·2^exp_k.
- Applies one term per clock into a full-width signed accumulator. Uses valid/ready handshakes on input and output.
- Sits between the weight-term decoder and the partial-sum adder tree in the PE datapath.

---
 rtl/po2_mult_pkg.sv | 19 +
 rtl/po2_term_shift.sv | 20 ++
 rtl/po2_term_mac_seq.sv | 119 +++++++++++
 tb/tb_po2_term_mac_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/po2_mult_pkg.sv
// rtl/po2_mult_pkg.sv - shared state encoding and width helpers for the power-of-two term MAC
package po2_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Holds MAX_TERMS worst-case shifted operands plus a sign bit.
   function automatic int acc_w(input int a_w, input int e_w, input int max_terms);
      return a_w + (1 << e_w) + $clog2(max_terms) + 1;
   endfunction

   function automatic int cnt_w(input int max_terms);
      return $clog2(max_terms + 1);
   endfunction

endpackage

// File: rtl/po2_term_shift.sv
// rtl/po2_term_shift.sv - extend operand to accumulator width and shift by one term exponent
module po2_term_shift #(
   parameter int A_W      = 16,
   parameter int E_W      = 4,
   parameter int ACC_W    = 35,
   parameter int A_SIGNED = 0
) (
   input  logic [A_W-1:0]   a,
   input  logic [E_W-1:0]   sh,
   output logic [ACC_W-1:0] t
);

   logic             ext_bit;
   logic [ACC_W-1:0] a_ext;

   assign ext_bit = (A_SIGNED != 0) ? a[A_W-1] : 1'b0;
   assign a_ext   = {{(ACC_W-A_W){ext_bit}}, a};
   assign t       = a_ext << sh;

endmodule

// File: rtl/po2_term_mac_seq.sv
// rtl/po2_term_mac_seq.sv - multiplies a by a sum of signed power-of-two terms, one term per clock
module po2_term_mac_seq
   import po2_mult_pkg::*;
#(
   parameter int A_W       = 16,
   parameter int E_W       = 4,
   parameter int MAX_TERMS = 4,
   parameter int A_SIGNED  = 0,
   localparam int CNT_W    = cnt_w(MAX_TERMS),
   localparam int ACC_W    = acc_w(A_W, E_W, MAX_TERMS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [A_W-1:0]           a,
   input  logic [MAX_TERMS*E_W-1:0] exp,
   input  logic [MAX_TERMS-1:0]     sgn,
   input  logic [CNT_W-1:0]         n_terms,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [ACC_W-1:0]         c,
   output logic                     busy
);

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TERMS);

   state_e                   state_q, state_d;
   logic [A_W-1:0]           a_q, a_d;
   logic [MAX_TERMS*E_W-1:0] exp_q, exp_d;
   logic [MAX_TERMS-1:0]     sgn_q, sgn_d;
   logic [CNT_W-1:0]         n_q, n_d;
   logic [CNT_W-1:0]         idx_q, idx_d;
   logic [ACC_W-1:0]         acc_q, acc_d;

   logic [E_W-1:0]           term_exp;
   logic                     term_sgn;
   logic [ACC_W-1:0]         term;

   always_comb begin
      term_exp = '0;
      term_sgn = 1'b0;
      for (int k = 0; k < MAX_TERMS; k++) begin
         if (idx_q == CNT_W'(k)) begin
            term_exp = exp_q[k*E_W +: E_W];
            term_sgn = sgn_q[k];
         end
      end
   end

   po2_term_shift #(
      .A_W      (A_W),
      .E_W      (E_W),
      .ACC_W    (ACC_W),
      .A_SIGNED (A_SIGNED)
   ) u_shift (
      .a  (a_q),
      .sh (term_exp),
      .t  (term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         exp_q   <= '0;
         sgn_q   <= '0;
         n_q     <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         exp_q   <= exp_d;
         sgn_q   <= sgn_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      exp_d   = exp_q;
      sgn_d   = sgn_q;
      n_d     = n_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (in_vld) begin
               a_d     = a;
               exp_d   = exp;
               sgn_d   = sgn;
               n_d     = (n_terms > MAX_N) ? MAX_N : n_terms;
               idx_d   = '0;
               acc_d   = '0;
               state_d = (n_d != '0) ? ACC : DONE;
            end
         end
         ACC: begin
            acc_d = term_sgn ? (acc_q - term) : (acc_q + term);
            idx_d = idx_q + 1'b1;
            if (idx_d == n_q) state_d = DONE;
         end
         DONE: begin
            if (out_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_rdy  = (state_q == IDLE);
   assign out_vld = (state_q == DONE);
   assign busy    = (state_q != IDLE);
   assign c       = acc_q;

endmodule

// File: tb/tb_po2_term_mac_seq.sv
// tb/tb_po2_term_mac_seq.sv - directed checks of unsigned and signed term MAC instances in lockstep
module tb_po2_term_mac_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vld;
   logic [15:0] a;
   logic [15:0] exp_i;
   logic [3:0]  sgn;
   logic [2:0]  n_terms;
   logic        out_rdy;

   logic        in_rdy_u, out_vld_u, busy_u;
   logic        in_rdy_s, out_vld_s, busy_s;
   logic [34:0] c_u, c_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   po2_term_mac_seq #(.A_W(16), .E_W(4), .MAX_TERMS(4), .A_SIGNED(0)) u_dut_u (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_u), .a(a), .exp(exp_i),
      .sgn(sgn), .n_terms(n_terms), .out_vld(out_vld_u), .out_rdy(out_rdy), .c(c_u), .busy(busy_u)
   );

   po2_term_mac_seq #(.A_W(16), .E_W(4), .MAX_TERMS(4), .A_SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_s), .a(a), .exp(exp_i),
      .sgn(sgn), .n_terms(n_terms), .out_vld(out_vld_s), .out_rdy(out_rdy), .c(c_s), .busy(busy_s)
   );

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] ev,
                         input logic [3:0] sv, input logic [2:0] nv,
                         input longint exp_u, input longint exp_s, input int exp_lat);
      int lat;
      chk({tag, "/in_rdy"}, in_rdy_u, 1);
      a = av; exp_i = ev; sgn = sv; n_terms = nv; in_vld = 1'b1;
      next_cycle();
      in_vld = 1'b0;
      chk({tag, "/busy"}, busy_u, 1);
      lat = 1;
      while (!out_vld_u && lat < 20) begin
         next_cycle();
         lat++;
      end
      chk({tag, "/latency"}, lat, exp_lat);
      chk({tag, "/c_unsigned"}, $signed(c_u), exp_u);
      chk({tag, "/c_signed"}, $signed(c_s), exp_s);
      chk({tag, "/out_vld_s"}, out_vld_s, 1);
      out_rdy = 1'b1;
      next_cycle();
      out_rdy = 1'b0;
      chk({tag, "/idle_rdy"}, in_rdy_u, 1);
      chk({tag, "/idle_vld"}, out_vld_u, 0);
   endtask

   initial begin
      rst = 1'b1; in_vld = 1'b0; a = '0; exp_i = '0; sgn = '0; n_terms = '0; out_rdy = 1'b0;
      @(negedge clk);
      next_cycle();
      rst = 1'b0;
      chk("reset/in_rdy", in_rdy_u, 1);
      chk("reset/out_vld", out_vld_u, 0);
      chk("reset/busy", busy_u, 0);
      chk("reset/c", $signed(c_u), 0);

      // exp/sgn packed as {t3,t2,t1,t0}
      run_op("a3_e31",   16'd3,     16'h0013, 4'b0000, 3'd2, 30, 30, 3);
      run_op("a5_16m1",  16'd5,     16'h0004, 4'b0010, 3'd2, 75, 75, 3);
      run_op("a5_neg",   16'd5,     16'h0000, 4'b0001, 3'd1, -5, -5, 2);
      run_op("am2",      16'hFFFE,  16'h0012, 4'b0010, 3'd3, 196602, -6, 4);
      run_op("max",      16'hFFFF,  16'hFFFF, 4'b0000, 3'd4, 64'd8589803520, -131072, 5);
      run_op("n0",       16'd123,   16'h3210, 4'b0000, 3'd0, 0, 0, 1);
      run_op("clamp",    16'd1,     16'h3210, 4'b0000, 3'd7, 15, 15, 5);
      run_op("dup",      16'd7,     16'h0222, 4'b0000, 3'd3, 84, 84, 4);
      run_op("top_exp",  16'd1,     16'h00FF, 4'b0010, 3'd2, 0, 0, 3);

      // Backpressure: result held, extra operand ignored
      a = 16'd3; exp_i = 16'h0013; sgn = 4'b0000; n_terms = 3'd2; in_vld = 1'b1;
      next_cycle();
      a = 16'd9; exp_i = 16'h0005;
      for (int i = 0; i < 12 && !out_vld_u; i++) next_cycle();
      for (int i = 0; i < 10; i++) begin
         chk("bp/c", $signed(c_u), 30);
         chk("bp/in_rdy", in_rdy_u, 0);
         next_cycle();
      end
      in_vld = 1'b0;
      out_rdy = 1'b1;
      next_cycle();
      out_rdy = 1'b0;
      chk("bp/in_rdy_after", in_rdy_u, 1);
      for (int i = 0; i < 4; i++) next_cycle();
      chk("bp/no_extra", out_vld_u, 0);

      // Reset mid-ACC
      a = 16'd5; exp_i = 16'h1111; sgn = 4'b0000; n_terms = 3'd4; in_vld = 1'b1;
      next_cycle();
      in_vld = 1'b0;
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      chk("rst/in_rdy", in_rdy_u, 1);
      chk("rst/out_vld", out_vld_u, 0);
      chk("rst/busy", busy_u, 0);
      chk("rst/c", $signed(c_u), 0);
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            if (out_vld_u) seen++;
            next_cycle();
         end
         chk("rst/no_result", seen, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
